// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// The IMEM_LOADER_CHECKSUM_EN macro adds the CSUM state to the enum.
package imem_loader_pkg;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_LOAD = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler shared by the length, payload and checksum fields.
// word_valid_o pulses combinationally on the transfer that carries the last byte of a word.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int N_BYTES = WORD_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   byte_en_i,
    input  logic [7:0]             byte_i,
    output logic                   word_valid_o,
    output logic [8*N_BYTES-1:0]   word_o
);

    localparam int CW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [8*N_BYTES-1:0]   shift_q, shift_d;
    logic                   lastByte;

    assign lastByte     = (cnt_q == CW'(N_BYTES - 1));
    assign word_o       = {byte_i, shift_q[8*N_BYTES-1:8]};
    assign word_valid_o = byte_en_i && lastByte && !clear_i;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_en_i) begin
            shift_d = {byte_i, shift_q[8*N_BYTES-1:8]};
            cnt_d   = lastByte ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program image into imem and holds the core in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit checksum of the written words.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N_WORDS = 20,
    parameter int AW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    output logic          byte_ready_o,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    output logic          core_rst_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW:0]   word_cnt_o
);

    loader_state_t  state_q, state_d;
    logic           ready_q, ready_d;
    logic           we_q, we_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [31:0]    len_q, len_d;
    logic           finish_q, finish_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]    csum_q, csum_d;
`endif

    logic           startAccept;
    logic           byteEn;
    logic           wordValid;
    logic [31:0]    word;
    logic [31:0]    cntInc;

    assign startAccept = start_i &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign byteEn      = byte_valid_i && ready_q;
    assign cntInc      = 32'(cnt_q) + 32'd1;

    byte_packer #(
        .N_BYTES      (WORD_BYTES)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (startAccept),
        .byte_en_i    (byteEn),
        .byte_i       (byte_i),
        .word_valid_o (wordValid),
        .word_o       (word)
    );

    // After the last payload word the FSM lingers one cycle in LOAD with ready low,
    // so the final write strobe never overlaps the core being released.
    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        finish_d = finish_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (startAccept) begin
                    state_d  = ST_LEN;
                    cnt_d    = '0;
                    finish_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            ST_LEN: begin
                if (wordValid) begin
                    len_d = word;
                    if (word == 32'd0) begin
                        state_d = ST_DONE;
                    end else if (word > 32'(N_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (finish_q) begin
                    finish_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d  = ST_CSUM;
`else
                    state_d  = ST_DONE;
`endif
                end else if (wordValid) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[AW-1:0];
                    wdata_d = word;
                    cnt_d   = cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q + word;
`endif
                    if (cntInc == len_q) begin
                        finish_d = 1'b1;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (wordValid) begin
                    state_d = (word == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = ((state_d == ST_LEN) || (state_d == ST_LOAD)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state_d == ST_CSUM)
`endif
                  ) && !finish_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            finish_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            finish_q <= finish_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign word_cnt_o   = cnt_q;
    assign core_rst_o   = (state_q != ST_DONE);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven load sessions plus reset and checksum sequences.
// Expected imem writes go to a scoreboard queue as bytes are driven and are popped by a write monitor.
module tb_imem_loader;

    localparam int N_WORDS = 20;
    localparam int AW      = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_wdata_o;
    logic          core_rst_o;
    logic          done_o;
    logic          err_o;
    logic [AW:0]   word_cnt_o;

    imem_loader #(
        .N_WORDS      (N_WORDS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .core_rst_o   (core_rst_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .word_cnt_o   (word_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        string            name;
        logic [31:0]      len;
        int               nWords;
        logic [3:0][31:0] words;
        bit               randValid;
        bit               badCsum;
        bit               expDone;
        bit               expErr;
    } vec_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int NV = 7;
`else
    localparam int NV = 5;
`endif

    vec_t  vecs [NV];
    vec_t  afterRst;
    wr_t   sbQ [$];
    wr_t   monExp;
    int    nCheck = 0;
    int    nFail  = 0;
    int    cycle  = 0;
    int    lastWeCycle = 0;
    bit    haveLast = 1'b0;
    bit    spacingCheck = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCheck++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst && imem_we_o) begin
            if (sbQ.size() == 0) begin
                nCheck++;
                nFail++;
                $display("[TB] FAIL unexpectedWrite: got addr %0d data 0x%08h, expected no write",
                         imem_addr_o, imem_wdata_o);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("wrAddr", 32'(imem_addr_o), 32'(monExp.addr));
                checkOutput("wrData", imem_wdata_o, monExp.data);
            end
            if (spacingCheck && haveLast) begin
                checkOutput("wrSpacing", cycle - lastWeCycle, 32'd4);
            end
            haveLast    = 1'b1;
            lastWeCycle = cycle;
        end
    end

    task automatic sendByte(input logic [7:0] b, input bit randValid);
        int  guard = 0;
        logic readyBefore;
        forever begin
            @(negedge clk);
            if (randValid && ($urandom_range(0, 1) == 0)) begin
                readyBefore  = byte_ready_o;
                byte_valid_i = 1'b0;
                byte_i       = 8'($urandom);
                #1;
                checkOutput("readyIndepOfValid", 32'(byte_ready_o), 32'(readyBefore));
            end else begin
                byte_valid_i = 1'b1;
                byte_i       = b;
                if (byte_ready_o) break;
            end
            guard++;
            if (guard > 200) begin
                checkOutput("byteHandshakeTimeout", 32'(byte_ready_o), 32'd1);
                break;
            end
        end
    endtask

    task automatic pulseStart();
        @(negedge clk);
        byte_valid_i = 1'b0;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
        checkOutput("startCoreRst", 32'(core_rst_o), 32'd1);
        checkOutput("startReady",   32'(byte_ready_o), 32'd1);
        checkOutput("startDone",    32'(done_o), 32'd0);
        checkOutput("startErr",     32'(err_o), 32'd0);
        checkOutput("startWordCnt", 32'(word_cnt_o), 32'd0);
    endtask

    task automatic sendWord(input logic [31:0] w, input bit randValid);
        for (int b = 0; b < 4; b++) sendByte(w[8*b +: 8], randValid);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] sum = 32'd0;
        int          waited = 0;
        bit          seen = 1'b0;
        $display("[TB] session %s", v.name);
        haveLast     = 1'b0;
        spacingCheck = !v.randValid;
        pulseStart();
        sendWord(v.len, v.randValid);
        if (v.len != 0 && v.len <= N_WORDS) begin
            for (int w = 0; w < v.nWords; w++) begin
                sum = sum + v.words[w];
                sbQ.push_back('{addr: AW'(w), data: v.words[w]});
                sendWord(v.words[w], v.randValid);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            sendWord(sum + (v.badCsum ? 32'd1 : 32'd0), v.randValid);
`endif
        end
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
            if (done_o || err_o) begin
                waited = c;
                seen   = 1'b1;
                break;
            end
        end
        checkOutput({v.name, "_finished"}, 32'(seen), 32'd1);
        checkOutput({v.name, "_done"},    32'(done_o), 32'(v.expDone));
        checkOutput({v.name, "_err"},     32'(err_o), 32'(v.expErr));
        checkOutput({v.name, "_coreRst"}, 32'(core_rst_o), 32'(!v.expDone));
        checkOutput({v.name, "_wordCnt"}, 32'(word_cnt_o), 32'(v.nWords));
        checkOutput({v.name, "_pendingWrites"}, 32'(sbQ.size()), 32'd0);
        if (v.len == 0) begin
            checkOutput({v.name, "_len0Latency"}, waited, 32'd1);
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (v.expDone && v.nWords > 0) begin
            checkOutput({v.name, "_doneAfterLastWrite"}, cycle - lastWeCycle, 32'd1);
        end
`endif
    endtask

    initial begin
        vecs[0] = '{name: "full3", len: 32'd3, nWords: 3,
                    words: {32'h0, 32'h002081B3, 32'h00A00113, 32'h00500093},
                    randValid: 1'b0, badCsum: 1'b0, expDone: 1'b1, expErr: 1'b0};
        vecs[1] = '{name: "rand3", len: 32'd3, nWords: 3,
                    words: {32'h0, 32'h002081B3, 32'h00A00113, 32'h00500093},
                    randValid: 1'b1, badCsum: 1'b0, expDone: 1'b1, expErr: 1'b0};
        vecs[2] = '{name: "len21", len: 32'h00000015, nWords: 0, words: '0,
                    randValid: 1'b0, badCsum: 1'b0, expDone: 1'b0, expErr: 1'b1};
        vecs[3] = '{name: "len0", len: 32'd0, nWords: 0, words: '0,
                    randValid: 1'b0, badCsum: 1'b0, expDone: 1'b1, expErr: 1'b0};
        vecs[4] = '{name: "one", len: 32'd1, nWords: 1,
                    words: {32'h0, 32'h0, 32'h0, 32'h12345678},
                    randValid: 1'b0, badCsum: 1'b0, expDone: 1'b1, expErr: 1'b0};
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[5] = '{name: "csumOk", len: 32'd2, nWords: 2,
                    words: {32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000001},
                    randValid: 1'b0, badCsum: 1'b0, expDone: 1'b1, expErr: 1'b0};
        vecs[6] = '{name: "csumBad", len: 32'd2, nWords: 2,
                    words: {32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000001},
                    randValid: 1'b0, badCsum: 1'b1, expDone: 1'b0, expErr: 1'b1};
`endif
        afterRst = '{name: "afterRst", len: 32'd1, nWords: 1,
                     words: {32'h0, 32'h0, 32'h0, 32'hCAFEF00D},
                     randValid: 1'b0, badCsum: 1'b0, expDone: 1'b1, expErr: 1'b0};

        rst          = 1'b1;
        start_i      = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstReady",   32'(byte_ready_o), 32'd0);
        checkOutput("rstWe",      32'(imem_we_o), 32'd0);
        checkOutput("rstAddr",    32'(imem_addr_o), 32'd0);
        checkOutput("rstWdata",   imem_wdata_o, 32'd0);
        checkOutput("rstCoreRst", 32'(core_rst_o), 32'd1);
        checkOutput("rstDone",    32'(done_o), 32'd0);
        checkOutput("rstErr",     32'(err_o), 32'd0);
        checkOutput("rstWordCnt", 32'(word_cnt_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) applyStimulus(vecs[i]);

        // Abort a 4-word load with an asynchronous reset after two words and a partial third.
        $display("[TB] session midReset");
        haveLast     = 1'b0;
        spacingCheck = 1'b1;
        pulseStart();
        sendWord(32'd4, 1'b0);
        sbQ.push_back('{addr: AW'(0), data: 32'h11111111});
        sendWord(32'h11111111, 1'b0);
        sbQ.push_back('{addr: AW'(1), data: 32'h22222222});
        sendWord(32'h22222222, 1'b0);
        sendByte(8'h33, 1'b0);
        @(negedge clk);
        byte_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstReady",   32'(byte_ready_o), 32'd0);
        checkOutput("midRstWe",      32'(imem_we_o), 32'd0);
        checkOutput("midRstAddr",    32'(imem_addr_o), 32'd0);
        checkOutput("midRstWdata",   imem_wdata_o, 32'd0);
        checkOutput("midRstCoreRst", 32'(core_rst_o), 32'd1);
        checkOutput("midRstDone",    32'(done_o), 32'd0);
        checkOutput("midRstErr",     32'(err_o), 32'd0);
        checkOutput("midRstWordCnt", 32'(word_cnt_o), 32'd0);
        checkOutput("midRstWritesBefore", 32'(sbQ.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(afterRst);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nCheck, nFail);
        $finish;
    end

endmodule
